// File: rtl/mod_count_wrap_monitor.sv
// Watches a mod-MOD counter: wrap ticks, saturating wrap count, threshold irq, sticky errors.
// Latency: every output is registered and reflects the cnt_in value sampled one clock earlier.
// Backpressure: none; the monitor samples every clock and never stalls the upstream counter.
module mod_count_wrap_monitor #(
   parameter int MOD    = 14,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        cnt_in,
   input  logic              en,
   input  logic              clear,
   input  logic [WRAP_W-1:0] thresh,
   input  logic              ack,
   output logic              wrap_tick,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              irq,
   output logic              err_illegal,
   output logic              err_skip
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      TRACK = 2'd2
   } state_t;

   // 5-bit compares so MOD = 16 and prev+1 at 15 do not alias back to zero.
   localparam logic [4:0]        MOD_V   = 5'(MOD);
   localparam logic [3:0]        LAST    = 4'(MOD - 1);
   localparam logic [WRAP_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [3:0]        prev_q, prev_d;
   logic              wrap_tick_q, wrap_tick_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
   logic              irq_q, irq_d;
   logic              err_illegal_q, err_illegal_d;
   logic              err_skip_q, err_skip_d;

   logic              tracking;
   logic              cur_illegal, prev_illegal;
   logic              is_wrap, is_hold, is_step;
   logic              wrap_ev, skip_ev, illegal_ev;
   logic [WRAP_W-1:0] count_base, count_inc;
   logic              irq_fire;

   // Classify the sampled transition; illegal current value outranks everything else.
   always_comb begin
      tracking     = (state_q == TRACK) && en;
      cur_illegal  = {1'b0, cnt_in} >= MOD_V;
      prev_illegal = {1'b0, prev_q} >= MOD_V;
      is_wrap      = (prev_q == LAST) && (cnt_in == 4'd0);
      is_hold      = (cnt_in == prev_q);
      is_step      = ({1'b0, cnt_in} == ({1'b0, prev_q} + 5'd1));
      illegal_ev   = tracking && cur_illegal;
      wrap_ev      = tracking && !cur_illegal && is_wrap;
      skip_ev      = tracking && !cur_illegal && !is_wrap &&
                     (prev_illegal || !(is_hold || is_step));
   end

   // Next-state: ack zeroes the count before a same-cycle wrap adds to it; clear overrides all.
   always_comb begin
      state_d       = state_q;
      prev_d        = prev_q;
      count_base    = ack ? '0 : wrap_count_q;
      count_inc     = (count_base == CNT_MAX) ? count_base : count_base + WRAP_W'(1);
      // A saturated count that cannot advance must not re-trigger the interrupt.
      irq_fire      = wrap_ev && (thresh != '0) && (count_inc == thresh) &&
                      (count_inc != count_base);
      wrap_tick_d   = wrap_ev;
      wrap_count_d  = wrap_ev ? count_inc : count_base;
      irq_d         = irq_fire ? 1'b1 : (ack ? 1'b0 : irq_q);
      err_illegal_d = err_illegal_q | illegal_ev;
      err_skip_d    = err_skip_q | skip_ev;

      case (state_q)
         IDLE: begin
            if (en) state_d = PRIME;
         end
         PRIME: begin
            if (en) begin
               prev_d  = cnt_in;
               state_d = TRACK;
            end else begin
               state_d = IDLE;
            end
         end
         TRACK: begin
            if (en) prev_d = cnt_in;
            else    state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (clear) begin
         state_d       = en ? PRIME : IDLE;
         wrap_tick_d   = 1'b0;
         wrap_count_d  = '0;
         irq_d         = 1'b0;
         err_illegal_d = 1'b0;
         err_skip_d    = 1'b0;
      end
   end

   // FSM state, sample history and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         prev_q        <= 4'd0;
         wrap_tick_q   <= 1'b0;
         wrap_count_q  <= '0;
         irq_q         <= 1'b0;
         err_illegal_q <= 1'b0;
         err_skip_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_q        <= prev_d;
         wrap_tick_q   <= wrap_tick_d;
         wrap_count_q  <= wrap_count_d;
         irq_q         <= irq_d;
         err_illegal_q <= err_illegal_d;
         err_skip_q    <= err_skip_d;
      end
   end

   assign wrap_tick   = wrap_tick_q;
   assign wrap_count  = wrap_count_q;
   assign irq         = irq_q;
   assign err_illegal = err_illegal_q;
   assign err_skip    = err_skip_q;

endmodule

// File: tb/tb_mod_count_wrap_monitor.sv
// Directed bench for mod_count_wrap_monitor (MOD=14), with an extra WRAP_W=4 instance for saturation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// No backpressure; stimulus advances one clock per sample.
module tb_mod_count_wrap_monitor;

   logic       clk;
   logic       rst_n;
   logic [3:0] cnt_in;
   logic       en;
   logic       clear;
   logic [7:0] thresh;
   logic [3:0] thresh4;
   logic       ack;

   logic       wrap_tick, irq, err_illegal, err_skip;
   logic [7:0] wrap_count;
   logic       wrap_tick4, irq4, err_illegal4, err_skip4;
   logic [3:0] wrap_count4;

   int checks;
   int errors;

   mod_count_wrap_monitor #(.MOD(14), .WRAP_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .en(en), .clear(clear),
      .thresh(thresh), .ack(ack), .wrap_tick(wrap_tick), .wrap_count(wrap_count),
      .irq(irq), .err_illegal(err_illegal), .err_skip(err_skip)
   );

   mod_count_wrap_monitor #(.MOD(14), .WRAP_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .en(en), .clear(clear),
      .thresh(thresh4), .ack(ack), .wrap_tick(wrap_tick4), .wrap_count(wrap_count4),
      .irq(irq4), .err_illegal(err_illegal4), .err_skip(err_skip4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input logic [3:0] v);
      cnt_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear(input logic [3:0] v);
      clear = 1'b1;
      cyc(v);
      clear = 1'b0;
   endtask

   // 1..13 then 0: one full period ending in a wrap.
   task automatic run_period();
      for (int v = 1; v <= 13; v++) cyc(4'(v));
      cyc(4'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; ack = 1'b0;
      thresh = 8'd0; thresh4 = 4'd0; cnt_in = 4'd0;
      #12;
      checks++;
      if (wrap_tick !== 1'b0 || wrap_count !== 8'd0 || irq !== 1'b0 ||
          err_illegal !== 1'b0 || err_skip !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: tick=%b count=%0d irq=%b ill=%b skip=%b, want all 0",
                  wrap_tick, wrap_count, irq, err_illegal, err_skip);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_wrap_basic();
      int ticks;
      ticks = 0;
      en = 1'b1; thresh = 8'd0;
      cyc(4'd0);              // IDLE -> PRIME
      cyc(4'd0);              // prime prev=0 -> TRACK
      for (int p = 0; p < 3; p++) begin
         for (int v = 1; v <= 13; v++) begin
            cyc(4'(v));
            if (wrap_tick === 1'b1) ticks++;
         end
         cyc(4'd0);
         if (wrap_tick === 1'b1) ticks++;
         checks++;
         if (wrap_tick !== 1'b1) begin
            errors++;
            $display("FAIL wrap_tick_period%0d: got %b want 1", p, wrap_tick);
         end
      end
      cyc(4'd1);
      if (wrap_tick === 1'b1) ticks++;
      checks++;
      if (ticks !== 3) begin
         errors++;
         $display("FAIL wrap_tick_total: got %0d want 3", ticks);
      end
      checks++;
      if (wrap_tick !== 1'b0) begin
         errors++;
         $display("FAIL wrap_tick_one_cycle: got %b want 0", wrap_tick);
      end
      checks++;
      if (wrap_count !== 8'd3 || irq !== 1'b0 || err_illegal !== 1'b0 || err_skip !== 1'b0) begin
         errors++;
         $display("FAIL basic_status: count=%0d irq=%b ill=%b skip=%b want 3/0/0/0",
                  wrap_count, irq, err_illegal, err_skip);
      end
   endtask

   task automatic test_irq_ack();
      thresh = 8'd2;
      do_clear(4'd0);
      cyc(4'd0);
      run_period();
      checks++;
      if (wrap_count !== 8'd1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_wrap1: count=%0d irq=%b want 1/0", wrap_count, irq);
      end
      run_period();
      checks++;
      if (wrap_count !== 8'd2 || irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_wrap2: count=%0d irq=%b want 2/1", wrap_count, irq);
      end
      run_period();
      checks++;
      if (wrap_count !== 8'd3 || irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_wrap3_held: count=%0d irq=%b want 3/1", wrap_count, irq);
      end
      ack = 1'b1;
      cyc(4'd1);
      ack = 1'b0;
      checks++;
      if (wrap_count !== 8'd0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_ack: count=%0d irq=%b want 0/0", wrap_count, irq);
      end
   endtask

   task automatic test_sequence_errors();
      thresh = 8'd0;
      do_clear(4'd7);
      cyc(4'd7);             // prime
      cyc(4'd7);             // hold
      cyc(4'd8);             // step
      checks++;
      if (err_skip !== 1'b0 || err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL hold_step: skip=%b ill=%b want 0/0", err_skip, err_illegal);
      end
      do_clear(4'd12);
      cyc(4'd12);
      cyc(4'd13);
      cyc(4'd0);
      checks++;
      if (wrap_tick !== 1'b1 || err_skip !== 1'b0 || wrap_count !== 8'd1) begin
         errors++;
         $display("FAIL wrap_not_skip: tick=%b skip=%b count=%0d want 1/0/1",
                  wrap_tick, err_skip, wrap_count);
      end
      do_clear(4'd5);
      cyc(4'd5);
      cyc(4'd9);
      checks++;
      if (err_skip !== 1'b1) begin
         errors++;
         $display("FAIL skip_set: got %b want 1", err_skip);
      end
      cyc(4'd10);
      checks++;
      if (err_skip !== 1'b1 || err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL skip_sticky: skip=%b ill=%b want 1/0", err_skip, err_illegal);
      end
   endtask

   task automatic test_illegal_clear();
      do_clear(4'd12);
      cyc(4'd12);
      cyc(4'd13);
      cyc(4'd0);
      cyc(4'd1);
      cyc(4'd15);
      checks++;
      if (err_illegal !== 1'b1 || err_skip !== 1'b0 || wrap_count !== 8'd1) begin
         errors++;
         $display("FAIL illegal_set: ill=%b skip=%b count=%0d want 1/0/1",
                  err_illegal, err_skip, wrap_count);
      end
      cyc(4'd15);
      checks++;
      if (err_skip !== 1'b0) begin
         errors++;
         $display("FAIL illegal_priority: skip=%b want 0", err_skip);
      end
      do_clear(4'd0);
      checks++;
      if (err_illegal !== 1'b0 || err_skip !== 1'b0 || wrap_count !== 8'd0) begin
         errors++;
         $display("FAIL clear_flags: ill=%b skip=%b count=%0d want 0/0/0",
                  err_illegal, err_skip, wrap_count);
      end
      cyc(4'd5);             // PRIME after clear: no comparison
      cyc(4'd6);
      checks++;
      if (err_skip !== 1'b0 || err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL clear_to_prime: skip=%b ill=%b want 0/0", err_skip, err_illegal);
      end
   endtask

   task automatic test_async_reset();
      thresh = 8'd5;
      do_clear(4'd0);
      cyc(4'd0);
      repeat (5) run_period();
      checks++;
      if (wrap_count !== 8'd5 || irq !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: count=%0d irq=%b want 5/1", wrap_count, irq);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (wrap_count !== 8'd0 || irq !== 1'b0 || wrap_tick !== 1'b0 ||
          err_illegal !== 1'b0 || err_skip !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: count=%0d irq=%b tick=%b ill=%b skip=%b want all 0",
                  wrap_count, irq, wrap_tick, err_illegal, err_skip);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      en = 1'b1;
      cyc(4'd0);
      cyc(4'd0);
      checks++;
      if (wrap_tick !== 1'b0 || err_skip !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_prime: tick=%b skip=%b want 0/0", wrap_tick, err_skip);
      end
      run_period();
      checks++;
      if (wrap_tick !== 1'b1 || wrap_count !== 8'd1) begin
         errors++;
         $display("FAIL post_reset_wrap: tick=%b count=%0d want 1/1", wrap_tick, wrap_count);
      end
   endtask

   task automatic test_saturate_ack_clear();
      thresh = 8'd0;
      do_clear(4'd0);
      cyc(4'd0);
      repeat (20) run_period();
      checks++;
      if (wrap_count4 !== 4'd15 || irq4 !== 1'b0) begin
         errors++;
         $display("FAIL saturate: count4=%0d irq4=%b want 15/0", wrap_count4, irq4);
      end
      checks++;
      if (wrap_count !== 8'd20) begin
         errors++;
         $display("FAIL count20: got %0d want 20", wrap_count);
      end
      thresh = 8'd1;
      for (int v = 1; v <= 13; v++) cyc(4'(v));
      ack = 1'b1;
      cyc(4'd0);
      ack = 1'b0;
      checks++;
      if (wrap_count4 !== 4'd1 || wrap_count !== 8'd1 || wrap_tick !== 1'b1 || irq !== 1'b1) begin
         errors++;
         $display("FAIL ack_with_wrap: count4=%0d count=%0d tick=%b irq=%b want 1/1/1/1",
                  wrap_count4, wrap_count, wrap_tick, irq);
      end
      for (int v = 1; v <= 13; v++) cyc(4'(v));
      ack = 1'b1;
      clear = 1'b1;
      cyc(4'd0);
      ack = 1'b0;
      clear = 1'b0;
      checks++;
      if (wrap_count !== 8'd0 || wrap_tick !== 1'b0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL clear_priority: count=%0d tick=%b irq=%b want 0/0/0",
                  wrap_count, wrap_tick, irq);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_wrap_basic();
      test_irq_ack();
      test_sequence_errors();
      test_illegal_clear();
      test_async_reset();
      test_saturate_ack_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_count_wrap_monitor.md
Name: mod_count_wrap_monitor

Overview:
Downstream consumer of the 4-bit modulo counter. Samples the counter's q output each clock and emits a one-cycle wrap tick when the count rolls from MOD-1 to 0. Accumulates wraps in a saturating counter and raises a threshold interrupt that is held until acknowledged. Flags illegal count values and non-sequential jumps as sticky errors.

Parameters:
MOD, 14, modulus of the upstream counter; legal values are 0..MOD-1 (2 <= MOD <= 16).
WRAP_W, 8, width of wrap_count.

Ports:
clk  input  1  rising-edge clock; same clock as the upstream counter.
rst_n  input  1  asynchronous, active-low reset.
cnt_in  input  4  upstream counter value (q).
en  input  1  monitor enable, level.
clear  input  1  synchronous clear of count, errors and irq.
thresh  input  WRAP_W  wrap-count interrupt threshold; 0 disables irq.
ack  input  1  interrupt acknowledge, single-cycle pulse.
wrap_tick  output  1  one-cycle pulse per detected wrap.
wrap_count  output  WRAP_W  saturating count of wraps.
irq  output  1  threshold interrupt, level, held until ack or clear.
err_illegal  output  1  sticky: cnt_in >= MOD was seen.
err_skip  output  1  sticky: a non-sequential legal transition was seen.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, prev=0, all outputs 0. Takes effect immediately, including mid-operation.
- FSM states:
  - IDLE: no comparisons. en=1 -> PRIME.
  - PRIME: prev <= cnt_in, no comparison -> TRACK.
  - TRACK: compares on every edge, prev <= cnt_in.
  - en=0 in PRIME or TRACK -> IDLE. wrap_count, errors and irq are held.
- TRACK classification, with cur = cnt_in sampled at the edge, in priority order:
  - cur >= MOD: set err_illegal. No other action.
  - prev == MOD-1 and cur == 0: wrap event.
  - cur == prev: hold. Legal, no action.
  - cur == prev+1: step. Legal, no action.
  - Anything else: set err_skip. This includes a transition from prev >= MOD to any value.
- Wrap event, all registered on the same edge (latency 1 clock after cnt_in shows 0):
  - wrap_tick=1 for exactly one cycle.
  - wrap_count <= wrap_count+1, saturating at 2^WRAP_W-1.
- irq:
  - Set when thresh != 0 and the updated wrap_count equals thresh on a wrap event.
  - If saturated at thresh, it does not re-fire unless the count is cleared.
- ack (any state):
  - Next edge: irq <= 0 and wrap_count <= 0.
  - A wrap in the same cycle as ack gives wrap_count = 1, and irq sets only if thresh == 1.
- clear:
  - Next edge: wrap_count, err_illegal, err_skip and irq <= 0, wrap_tick <= 0.
  - State <= PRIME if en=1, else IDLE.
  - clear has priority over ack and over a wrap in the same cycle.
- Error flags are sticky until clear or reset. They do not stop wrap counting.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. en=1, thresh=0, cnt_in 0..13 repeating for 3 periods -> wrap_tick pulses exactly 3 times, each 1 cycle, in the cycle after cnt_in=0 is sampled. wrap_count=3, irq=0, no errors.
2. thresh=2, two full periods -> irq rises on the same edge wrap_count becomes 2. irq stays high through a third wrap (count=3). ack pulse -> next cycle irq=0, wrap_count=0.
3. Sequences 7,7,8 then 5->9 then 13->0 -> hold and step produce no flag. 5->9 sets err_skip=1 (sticky). 13->0 produces wrap_tick, not err_skip. err_illegal stays 0.
4. cnt_in=15 injected in TRACK -> err_illegal=1, err_skip=0. clear pulse -> both flags 0, state PRIME, wrap_count=0.
5. wrap_count=5, irq=1, assert rst_n=0 mid-cycle -> outputs go 0 immediately. After release with en=1 and cnt_in=0, no wrap_tick on the first sample (PRIME). A subsequent 13->0 gives a tick.
6. WRAP_W=4, thresh=0, 20 wraps -> wrap_count saturates at 15 and holds. ack coincident with a wrap -> wrap_count=1.
